// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection controllers: phase codes, arbiter
// state encoding and the light codes used by traffic_light_controller.
package traffic_pkg;

  localparam int unsigned NUM_REQ = 3;

  localparam logic [1:0] PH_NS  = 2'b00;
  localparam logic [1:0] PH_EW  = 2'b01;
  localparam logic [1:0] PH_PED = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GRANT  = 2'b01,
    ACTIVE = 2'b10
  } arb_state_e;

  localparam logic [1:0] LT_RED    = 2'b00;
  localparam logic [1:0] LT_GREEN  = 2'b01;
  localparam logic [1:0] LT_YELLOW = 2'b10;

endpackage

// File: rtl/rr_starve_select.sv
// Combinational 3-way picker: lowest-index starved requester wins, otherwise
// round-robin starting just after the last granted phase.
module rr_starve_select
  import traffic_pkg::*;
(
  input  logic [2:0] req_i,
  input  logic [2:0] starved_i,
  input  logic [1:0] last_i,
  output logic       valid_c_o,
  output logic [1:0] sel_c_o
);

  always_comb begin
    valid_c_o = |req_i;
    sel_c_o   = PH_NS;
    if (|starved_i) begin
      if (starved_i[0])      sel_c_o = PH_NS;
      else if (starved_i[1]) sel_c_o = PH_EW;
      else                   sel_c_o = PH_PED;
    end else begin
      case (last_i)
        PH_NS: begin
          if (req_i[1])      sel_c_o = PH_EW;
          else if (req_i[2]) sel_c_o = PH_PED;
          else               sel_c_o = PH_NS;
        end
        PH_EW: begin
          if (req_i[2])      sel_c_o = PH_PED;
          else if (req_i[0]) sel_c_o = PH_NS;
          else               sel_c_o = PH_EW;
        end
        default: begin
          if (req_i[0])      sel_c_o = PH_NS;
          else if (req_i[1]) sel_c_o = PH_EW;
          else               sel_c_o = PH_PED;
        end
      endcase
    end
  end

endmodule

// File: rtl/phase_request_arbiter.sv
// Latches NS/EW/PED demand, offers one phase at a time to the light controller
// over valid/ready, and flags a sticky fault if a phase never completes.
module phase_request_arbiter
  import traffic_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 8,
  parameter int unsigned WATCHDOG = 64,
  parameter int unsigned CW       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sensor_ns,
  input  logic       sensor_ew,
  input  logic       ped_button,
  input  logic       grant_ready,
  input  logic       phase_done,
  output logic       grant_valid,
  output logic [1:0] grant_phase,
  output logic [2:0] pending,
  output logic       fault
);

  arb_state_e                       state_q, state_d;
  logic                             grant_valid_q, grant_valid_d;
  logic [1:0]                       grant_phase_q, grant_phase_d;
  logic [1:0]                       last_q, last_d;
  logic [NUM_REQ-1:0]               pending_q, pending_d;
  logic                             fault_q, fault_d;
  logic [CW-1:0]                    wd_q, wd_d;
  logic [NUM_REQ-1:0][CW-1:0]       wait_q, wait_d;

  logic [NUM_REQ-1:0] req_in;
  logic [NUM_REQ-1:0] clr;
  logic [NUM_REQ-1:0] starved;
  logic               handshake;
  logic               sel_valid;
  logic [1:0]         sel_phase;

  assign req_in    = {ped_button, sensor_ew, sensor_ns};
  assign handshake = (state_q == GRANT) && grant_ready;
  assign clr       = handshake ? (3'b001 << grant_phase_q) : 3'b000;

  rr_starve_select u_sel (
    .req_i     (pending_q),
    .starved_i (starved),
    .last_i    (last_q),
    .valid_c_o (sel_valid),
    .sel_c_o   (sel_phase)
  );

  // Request latching and per-requester wait counters; a new demand beats the clear.
  always_comb begin
    pending_d = (pending_q & ~clr) | req_in;
    wait_d    = wait_q;
    starved   = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      starved[i] = (wait_q[i] == CW'(MAX_WAIT));
      if (!pending_d[i]) begin
        wait_d[i] = '0;
      end else if (pending_q[i] && !starved[i] &&
                   !((state_q != IDLE) && (grant_phase_q == 2'(i)))) begin
        wait_d[i] = wait_q[i] + CW'(1);
      end
    end
  end

  // Grant FSM; phase_done takes priority over a watchdog expiry on the same edge.
  always_comb begin
    state_d       = state_q;
    grant_valid_d = grant_valid_q;
    grant_phase_d = grant_phase_q;
    last_d        = last_q;
    wd_d          = wd_q;
    fault_d       = fault_q;
    case (state_q)
      IDLE: begin
        if (sel_valid) begin
          state_d       = GRANT;
          grant_valid_d = 1'b1;
          grant_phase_d = sel_phase;
        end
      end
      GRANT: begin
        if (grant_ready) begin
          state_d       = ACTIVE;
          grant_valid_d = 1'b0;
          last_d        = grant_phase_q;
          wd_d          = '0;
        end
      end
      ACTIVE: begin
        if (phase_done) begin
          state_d = IDLE;
        end else if (wd_q == CW'(WATCHDOG - 1)) begin
          state_d = IDLE;
          fault_d = 1'b1;
        end else begin
          wd_d = wd_q + CW'(1);
        end
      end
      default: begin
        state_d       = IDLE;
        grant_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      grant_valid_q <= 1'b0;
      grant_phase_q <= PH_NS;
      last_q        <= PH_PED;
      pending_q     <= '0;
      fault_q       <= 1'b0;
      wd_q          <= '0;
      wait_q        <= '0;
    end else begin
      state_q       <= state_d;
      grant_valid_q <= grant_valid_d;
      grant_phase_q <= grant_phase_d;
      last_q        <= last_d;
      pending_q     <= pending_d;
      fault_q       <= fault_d;
      wd_q          <= wd_d;
      wait_q        <= wait_d;
    end
  end

  assign grant_valid = grant_valid_q;
  assign grant_phase = grant_phase_q;
  assign pending     = pending_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_phase_request_arbiter.sv
// Directed bench for phase_request_arbiter: latency, round-robin, backpressure,
// starvation override, watchdog and mid-operation reset.
module tb_phase_request_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       sensor_ns, sensor_ew, ped_button;
  logic       grant_ready, phase_done;
  logic       grant_valid;
  logic [1:0] grant_phase;
  logic [2:0] pending;
  logic       fault;

  int n_cmp = 0;
  int n_err = 0;

  phase_request_arbiter #(.MAX_WAIT(8), .WATCHDOG(64), .CW(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .sensor_ns   (sensor_ns),
    .sensor_ew   (sensor_ew),
    .ped_button  (ped_button),
    .grant_ready (grant_ready),
    .phase_done  (phase_done),
    .grant_valid (grant_valid),
    .grant_phase (grant_phase),
    .pending     (pending),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sensor_ns = 1'b0; sensor_ew = 1'b0; ped_button = 1'b0;
    grant_ready = 1'b0; phase_done = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (grant_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", grant_valid); end
    n_cmp++; if (grant_phase !== 2'b00) begin n_err++; $display("FAIL reset_phase: got %b want 00", grant_phase); end
    n_cmp++; if (pending !== 3'b000) begin n_err++; $display("FAIL reset_pending: got %b want 000", pending); end
    n_cmp++; if (fault !== 1'b0) begin n_err++; $display("FAIL reset_fault: got %b want 0", fault); end
  endtask

  task automatic test_single_ns();
    do_reset();
    grant_ready = 1'b1;
    sensor_ns = 1'b1;
    tick();
    sensor_ns = 1'b0;
    n_cmp++; if (pending !== 3'b001) begin n_err++; $display("FAIL ns_pending: got %b want 001", pending); end
    n_cmp++; if (grant_valid !== 1'b0) begin n_err++; $display("FAIL ns_valid_early: got %b want 0", grant_valid); end
    tick();
    n_cmp++; if (grant_valid !== 1'b1) begin n_err++; $display("FAIL ns_valid: got %b want 1", grant_valid); end
    n_cmp++; if (grant_phase !== 2'b00) begin n_err++; $display("FAIL ns_phase: got %b want 00", grant_phase); end
    tick();
    n_cmp++; if (pending !== 3'b000) begin n_err++; $display("FAIL ns_pending_clr: got %b want 000", pending); end
    n_cmp++; if (grant_valid !== 1'b0) begin n_err++; $display("FAIL ns_valid_clr: got %b want 0", grant_valid); end
    phase_done = 1'b1;
    tick();
    phase_done = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_ph [3];
    logic [2:0] exp_pend [3];
    exp_ph[0] = 2'b00; exp_ph[1] = 2'b01; exp_ph[2] = 2'b10;
    exp_pend[0] = 3'b110; exp_pend[1] = 3'b100; exp_pend[2] = 3'b000;
    do_reset();
    grant_ready = 1'b1;
    sensor_ns = 1'b1; sensor_ew = 1'b1; ped_button = 1'b1;
    tick();
    sensor_ns = 1'b0; sensor_ew = 1'b0; ped_button = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++; if (grant_valid !== 1'b1 || grant_phase !== exp_ph[k]) begin
        n_err++; $display("FAIL rr_grant[%0d]: got valid=%b phase=%b want valid=1 phase=%b", k, grant_valid, grant_phase, exp_ph[k]);
      end
      tick();
      n_cmp++; if (pending !== exp_pend[k]) begin
        n_err++; $display("FAIL rr_pending[%0d]: got %b want %b", k, pending, exp_pend[k]);
      end
      tick();
      tick();
      phase_done = 1'b1;
      tick();
      phase_done = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    grant_ready = 1'b0;
    sensor_ew = 1'b1;
    tick();
    sensor_ew = 1'b0;
    tick();
    n_cmp++; if (grant_valid !== 1'b1 || grant_phase !== 2'b01) begin
      n_err++; $display("FAIL bp_grant: got valid=%b phase=%b want valid=1 phase=01", grant_valid, grant_phase);
    end
    for (int k = 0; k < 5; k++) begin
      ped_button = (k == 2);
      tick();
      n_cmp++; if (grant_valid !== 1'b1 || grant_phase !== 2'b01) begin
        n_err++; $display("FAIL bp_hold[%0d]: got valid=%b phase=%b want valid=1 phase=01", k, grant_valid, grant_phase);
      end
    end
    ped_button = 1'b0;
    n_cmp++; if (pending !== 3'b110) begin n_err++; $display("FAIL bp_pending: got %b want 110", pending); end
    grant_ready = 1'b1;
    tick();
    n_cmp++; if (grant_valid !== 1'b0 || pending !== 3'b100) begin
      n_err++; $display("FAIL bp_handshake: got valid=%b pending=%b want valid=0 pending=100", grant_valid, pending);
    end
  endtask

  task automatic test_starvation();
    do_reset();
    grant_ready = 1'b1;
    sensor_ns = 1'b1; ped_button = 1'b1;
    tick();
    sensor_ns = 1'b0; ped_button = 1'b0;
    tick();
    n_cmp++; if (grant_phase !== 2'b00) begin n_err++; $display("FAIL st_first: got %b want 00", grant_phase); end
    tick();
    for (int k = 0; k < 12; k++) begin
      sensor_ew  = (k == 8);
      phase_done = (k == 11);
      tick();
    end
    sensor_ew = 1'b0; phase_done = 1'b0;
    n_cmp++; if (pending !== 3'b110) begin n_err++; $display("FAIL st_pending: got %b want 110", pending); end
    tick();
    n_cmp++; if (grant_valid !== 1'b1 || grant_phase !== 2'b10) begin
      n_err++; $display("FAIL st_override: got valid=%b phase=%b want valid=1 phase=10", grant_valid, grant_phase);
    end
  endtask

  task automatic test_watchdog();
    do_reset();
    grant_ready = 1'b1;
    sensor_ns = 1'b1;
    tick();
    sensor_ns = 1'b0;
    tick();
    tick();
    // NS: phase_done coincides with the timeout edge
    sensor_ew = 1'b1;
    for (int k = 0; k < 63; k++) begin
      tick();
      sensor_ew = 1'b0;
    end
    n_cmp++; if (fault !== 1'b0 || grant_valid !== 1'b0) begin
      n_err++; $display("FAIL wd_pre_edge: got fault=%b valid=%b want 0 0", fault, grant_valid);
    end
    phase_done = 1'b1;
    tick();
    phase_done = 1'b0;
    n_cmp++; if (fault !== 1'b0) begin n_err++; $display("FAIL wd_done_wins: got %b want 0", fault); end
    tick();
    n_cmp++; if (grant_valid !== 1'b1 || grant_phase !== 2'b01) begin
      n_err++; $display("FAIL wd_ew_grant: got valid=%b phase=%b want valid=1 phase=01", grant_valid, grant_phase);
    end
    tick();
    ped_button = 1'b1;
    for (int k = 0; k < 63; k++) begin
      tick();
      ped_button = 1'b0;
    end
    n_cmp++; if (fault !== 1'b0) begin n_err++; $display("FAIL wd_63: got %b want 0", fault); end
    tick();
    n_cmp++; if (fault !== 1'b1 || grant_valid !== 1'b0) begin
      n_err++; $display("FAIL wd_64: got fault=%b valid=%b want fault=1 valid=0", fault, grant_valid);
    end
    tick();
    n_cmp++; if (grant_valid !== 1'b1 || grant_phase !== 2'b10 || fault !== 1'b1) begin
      n_err++; $display("FAIL wd_after: got valid=%b phase=%b fault=%b want 1 10 1", grant_valid, grant_phase, fault);
    end
  endtask

  task automatic test_reset_mid();
    // Still in GRANT(PED) with fault set from the watchdog test
    grant_ready = 1'b0;
    sensor_ew = 1'b1;
    tick();
    sensor_ew = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++; if (grant_valid !== 1'b0 || pending !== 3'b000 || fault !== 1'b0 || grant_phase !== 2'b00) begin
      n_err++; $display("FAIL rst_grant: got valid=%b pending=%b fault=%b phase=%b want 0 000 0 00", grant_valid, pending, fault, grant_phase);
    end
    grant_ready = 1'b1;
    sensor_ew = 1'b1;
    tick();
    sensor_ew = 1'b0;
    tick();
    tick();
    ped_button = 1'b1;
    tick();
    ped_button = 1'b0;
    n_cmp++; if (grant_phase !== 2'b01 || pending !== 3'b100) begin
      n_err++; $display("FAIL rst_pre_active: got phase=%b pending=%b want 01 100", grant_phase, pending);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++; if (grant_valid !== 1'b0 || pending !== 3'b000 || fault !== 1'b0 || grant_phase !== 2'b00) begin
      n_err++; $display("FAIL rst_active: got valid=%b pending=%b fault=%b phase=%b want 0 000 0 00", grant_valid, pending, fault, grant_phase);
    end
    sensor_ew = 1'b1; ped_button = 1'b1; sensor_ns = 1'b1;
    tick();
    sensor_ew = 1'b0; ped_button = 1'b0; sensor_ns = 1'b0;
    tick();
    n_cmp++; if (grant_valid !== 1'b1 || grant_phase !== 2'b00) begin
      n_err++; $display("FAIL rst_ns_first: got valid=%b phase=%b want 1 00", grant_valid, grant_phase);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_ns();
    test_round_robin();
    test_backpressure();
    test_starvation();
    test_watchdog();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
